seq_multiplier: RTL and testbench

Iterative shift-add multiplier in the EX stage of the CPU datapath. It produces a 2*size-bit product as separate HI and LO words. The LO word feeds the data2_i leg of the write-back 3-to-1 select mux, and the HI word is written to the HI register. It replaces a combinational multiplier with a multi-cycle unit driven by a start/busy/done handshake; the hazard unit stalls on busy_o.

---
 rtl/seq_multiplier_if.sv | 13 +
 rtl/seq_multiplier.sv | 76 +++++++
 tb/tb_seq_multiplier.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/seq_multiplier_if.sv
// seq_multiplier_if: start/busy/done handshake, operands and product words of the iterative multiplier
interface seq_multiplier_if #(parameter int size = 32);
  logic            start_i;
  logic            signed_i;
  logic [size-1:0] src1_i;
  logic [size-1:0] src2_i;
  logic            busy_o;
  logic            done_o;
  logic [size-1:0] result_hi_o;
  logic [size-1:0] result_lo_o;
  modport master (output start_i, signed_i, src1_i, src2_i, input busy_o, done_o, result_hi_o, result_lo_o);
  modport slave  (input start_i, signed_i, src1_i, src2_i, output busy_o, done_o, result_hi_o, result_lo_o);
endinterface

// File: rtl/seq_multiplier.sv
// seq_multiplier: radix-2 shift-add multiplier, magnitude multiply then sign fix-up, HI/LO result words
module seq_multiplier #(parameter int size = 32) (
  input logic             clk_i,
  input logic             rst_i,
  seq_multiplier_if.slave bus
);
  localparam int cw = $clog2(size) + 1;
  typedef enum logic [1:0] {IDLE, RUN, SIGN, DONE} state_t;
  state_t            r_state, w_next;
  logic [2*size-1:0] r_acc, r_mcand, w_final;
  logic [size-1:0]   r_mplier, r_hi, r_lo, w_abs1, w_abs2;
  logic [cw-1:0]     r_cnt;
  logic              r_neg, w_accept, w_busy, w_done;
  assign w_abs1   = (bus.signed_i && bus.src1_i[size-1]) ? -bus.src1_i : bus.src1_i;
  assign w_abs2   = (bus.signed_i && bus.src2_i[size-1]) ? -bus.src2_i : bus.src2_i;
  assign w_final  = r_neg ? -r_acc : r_acc;
  assign w_accept = bus.start_i && (r_state == IDLE || r_state == DONE);
  assign bus.busy_o      = w_busy;
  assign bus.done_o      = w_done;
  assign bus.result_hi_o = r_hi;
  assign bus.result_lo_o = r_lo;
  // State register; reset abandons any in-flight operation
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) r_state <= IDLE;
    else        r_state <= w_next;
  end
  // Next state and handshake outputs; start is only honoured while not busy
  always_comb begin
    w_next = r_state;
    w_busy = 1'b0;
    w_done = 1'b0;
    case (r_state)
      IDLE: w_next = bus.start_i ? RUN : IDLE;
      RUN: begin
        w_busy = 1'b1;
        w_next = (r_cnt == cw'(size - 1)) ? SIGN : RUN;
      end
      SIGN: begin
        w_busy = 1'b1;
        w_next = DONE;
      end
      DONE: begin
        w_done = 1'b1;
        w_next = bus.start_i ? RUN : IDLE;
      end
      default: w_next = IDLE;
    endcase
  end
  // Datapath: latch magnitudes on accept, one add/shift per RUN cycle, sign-correct and publish in SIGN
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_neg    <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else if (w_accept) begin
      r_acc    <= '0;
      r_mcand  <= {{size{1'b0}}, w_abs1};
      r_mplier <= w_abs2;
      r_cnt    <= '0;
      r_neg    <= bus.signed_i & (bus.src1_i[size-1] ^ bus.src2_i[size-1]);
    end else if (r_state == RUN) begin
      r_acc    <= r_mplier[0] ? r_acc + r_mcand : r_acc;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + 1'b1;
    end else if (r_state == SIGN) begin
      r_acc <= w_final;
      r_hi  <= w_final[2*size-1:size];
      r_lo  <= w_final[size-1:0];
    end
  end
endmodule

// File: tb/tb_seq_multiplier.sv
// tb_seq_multiplier: directed checks of reset, products, busy handling, back-to-back and mid-run reset
module tb_seq_multiplier;
  localparam int size = 32;
  localparam int lat_exp = size + 2;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   passed = 0;
  seq_multiplier_if #(.size(size)) bus ();
  seq_multiplier #(.size(size)) dut (.clk_i(clk), .rst_i(rst_n), .bus(bus));
  always #5 clk = ~clk;

  task automatic do_start(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.signed_i = sgn;
    bus.src1_i   = a;
    bus.src2_i   = b;
    bus.start_i  = 1'b1;
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
    bus.src1_i  = 32'h1234_5678;
    bus.src2_i  = 32'h8765_4321;
  endtask

  task automatic wait_done(output int lat, output int busy_n);
    lat = -1;
    busy_n = 0;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      if (bus.busy_o) busy_n++;
      if (bus.done_o) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic test_reset;
    #2;
    total++; if (bus.busy_o !== 1'b0) $display("FAIL reset_busy got %b want 0", bus.busy_o); else passed++;
    total++; if (bus.done_o !== 1'b0) $display("FAIL reset_done got %b want 0", bus.done_o); else passed++;
    total++; if (bus.result_hi_o !== 32'h0) $display("FAIL reset_hi got %h want 0", bus.result_hi_o); else passed++;
    total++; if (bus.result_lo_o !== 32'h0) $display("FAIL reset_lo got %h want 0", bus.result_lo_o); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_unsigned_small;
    int lat, bn;
    do_start(1'b0, 32'd6, 32'd7);
    wait_done(lat, bn);
    total++; if (lat !== lat_exp) $display("FAIL small_latency got %0d want %0d", lat, lat_exp); else passed++;
    total++; if (bn !== size + 1) $display("FAIL small_busy_cycles got %0d want %0d", bn, size + 1); else passed++;
    total++; if (bus.result_hi_o !== 32'h0) $display("FAIL small_hi got %h want 00000000", bus.result_hi_o); else passed++;
    total++; if (bus.result_lo_o !== 32'h2A) $display("FAIL small_lo got %h want 0000002a", bus.result_lo_o); else passed++;
    @(negedge clk);
    total++; if (bus.done_o !== 1'b0) $display("FAIL small_done_pulse got %b want 0", bus.done_o); else passed++;
    total++; if (bus.busy_o !== 1'b0) $display("FAIL small_idle_busy got %b want 0", bus.busy_o); else passed++;
  endtask

  task automatic test_signed;
    int lat, bn;
    do_start(1'b1, 32'hFFFF_FFFD, 32'd5);
    wait_done(lat, bn);
    total++; if (bus.result_hi_o !== 32'hFFFF_FFFF) $display("FAIL smul_hi got %h want ffffffff", bus.result_hi_o); else passed++;
    total++; if (bus.result_lo_o !== 32'hFFFF_FFF1) $display("FAIL smul_lo got %h want fffffff1", bus.result_lo_o); else passed++;
    do_start(1'b0, 32'hFFFF_FFFD, 32'd5);
    wait_done(lat, bn);
    total++; if (bus.result_hi_o !== 32'h4) $display("FAIL umul_hi got %h want 00000004", bus.result_hi_o); else passed++;
    total++; if (bus.result_lo_o !== 32'hFFFF_FFF1) $display("FAIL umul_lo got %h want fffffff1", bus.result_lo_o); else passed++;
    do_start(1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFA);
    wait_done(lat, bn);
    total++; if (bus.result_hi_o !== 32'h0) $display("FAIL negneg_hi got %h want 00000000", bus.result_hi_o); else passed++;
    total++; if (bus.result_lo_o !== 32'h2A) $display("FAIL negneg_lo got %h want 0000002a", bus.result_lo_o); else passed++;
  endtask

  task automatic test_extremes;
    int lat, bn;
    do_start(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(lat, bn);
    total++; if (bus.result_hi_o !== 32'hFFFF_FFFE) $display("FAIL umax_hi got %h want fffffffe", bus.result_hi_o); else passed++;
    total++; if (bus.result_lo_o !== 32'h1) $display("FAIL umax_lo got %h want 00000001", bus.result_lo_o); else passed++;
    do_start(1'b1, 32'h8000_0000, 32'h8000_0000);
    wait_done(lat, bn);
    total++; if (bus.result_hi_o !== 32'h4000_0000) $display("FAIL smin_hi got %h want 40000000", bus.result_hi_o); else passed++;
    total++; if (bus.result_lo_o !== 32'h0) $display("FAIL smin_lo got %h want 00000000", bus.result_lo_o); else passed++;
  endtask

  task automatic test_start_while_busy;
    int ndone, lat;
    logic [31:0] lo;
    ndone = 0;
    lat = -1;
    lo = 32'hDEAD_BEEF;
    do_start(1'b0, 32'd2, 32'd3);
    for (int n = 1; n <= lat_exp + 40; n++) begin
      @(negedge clk);
      if (bus.done_o) begin
        ndone++;
        if (lat < 0) begin
          lat = n;
          lo = bus.result_lo_o;
        end
      end
      if (n == 10) begin
        bus.src1_i  = 32'd9;
        bus.src2_i  = 32'd9;
        bus.start_i = 1'b1;
      end
      if (n == 11) bus.start_i = 1'b0;
    end
    total++; if (ndone !== 1) $display("FAIL busy_done_count got %0d want 1", ndone); else passed++;
    total++; if (lat !== lat_exp) $display("FAIL busy_latency got %0d want %0d", lat, lat_exp); else passed++;
    total++; if (lo !== 32'd6) $display("FAIL busy_lo got %h want 00000006", lo); else passed++;
  endtask

  task automatic test_back_to_back;
    int n1, n2, held_bad;
    n1 = -1;
    n2 = -1;
    held_bad = 0;
    @(negedge clk);
    bus.signed_i = 1'b0;
    bus.src1_i   = 32'd4;
    bus.src2_i   = 32'd5;
    bus.start_i  = 1'b1;
    @(posedge clk);
    #1;
    bus.src1_i = 32'hFFFF_FFFF;
    bus.src2_i = 32'd2;
    for (int n = 1; n <= 3 * lat_exp; n++) begin
      @(negedge clk);
      if (bus.done_o) begin
        if (n1 < 0) begin
          n1 = n;
          total++; if (bus.result_lo_o !== 32'd20) $display("FAIL b2b_first_lo got %h want 00000014", bus.result_lo_o); else passed++;
        end else begin
          n2 = n;
          total++; if (bus.result_hi_o !== 32'h1) $display("FAIL b2b_second_hi got %h want 00000001", bus.result_hi_o); else passed++;
          total++; if (bus.result_lo_o !== 32'hFFFF_FFFE) $display("FAIL b2b_second_lo got %h want fffffffe", bus.result_lo_o); else passed++;
          break;
        end
      end else if (n1 > 0) begin
        bus.start_i = 1'b0;
        if (bus.result_lo_o !== 32'd20 || bus.result_hi_o !== 32'h0) held_bad++;
      end
    end
    bus.start_i = 1'b0;
    total++; if (n1 !== lat_exp) $display("FAIL b2b_first_latency got %0d want %0d", n1, lat_exp); else passed++;
    total++; if (n2 - n1 !== lat_exp) $display("FAIL b2b_gap got %0d want %0d", n2 - n1, lat_exp); else passed++;
    total++; if (held_bad !== 0) $display("FAIL b2b_held_result got %0d bad cycles want 0", held_bad); else passed++;
  endtask

  task automatic test_reset_mid;
    int lat, bn, stray;
    stray = 0;
    do_start(1'b0, 32'd7, 32'd9);
    repeat (14) @(negedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (bus.busy_o !== 1'b0) $display("FAIL rmid_busy got %b want 0", bus.busy_o); else passed++;
    total++; if (bus.done_o !== 1'b0) $display("FAIL rmid_done got %b want 0", bus.done_o); else passed++;
    total++; if (bus.result_hi_o !== 32'h0) $display("FAIL rmid_hi got %h want 0", bus.result_hi_o); else passed++;
    total++; if (bus.result_lo_o !== 32'h0) $display("FAIL rmid_lo got %h want 0", bus.result_lo_o); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (50) begin
      @(negedge clk);
      if (bus.done_o || bus.busy_o) stray++;
    end
    total++; if (stray !== 0) $display("FAIL rmid_stray_activity got %0d cycles want 0", stray); else passed++;
    do_start(1'b0, 32'd3, 32'd3);
    wait_done(lat, bn);
    total++; if (lat !== lat_exp) $display("FAIL rmid_new_latency got %0d want %0d", lat, lat_exp); else passed++;
    total++; if (bus.result_lo_o !== 32'd9) $display("FAIL rmid_new_lo got %h want 00000009", bus.result_lo_o); else passed++;
  endtask

  initial begin
    bus.start_i  = 1'b0;
    bus.signed_i = 1'b0;
    bus.src1_i   = '0;
    bus.src2_i   = '0;
    test_reset;
    test_unsigned_small;
    test_signed;
    test_extremes;
    test_start_while_busy;
    test_back_to_back;
    test_reset_mid;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
